adventure_autoplayer: RTL and testbench

- Drives the N/S/E/W move inputs of the adventure game, acting as the transmitting player on the game's move interface.
- A route of up to DEPTH moves is loaded through a write port, then replayed as one-cycle direction pulses, paced by a programmable gap.
- After each move it watches the game's WIN/DIE outputs, stops on either, and reports the outcome and the move count.
- Used as a self-playing stimulus source in the game bench and as a demo driver on the board.

---
 rtl/adventure_pkg.sv | 30 +++
 rtl/adventure_autoplayer_route_mem.sv | 42 ++++
 rtl/adventure_autoplayer.sv | 143 ++++++++++++++
 tb/tb_adventure_autoplayer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/adventure_pkg.sv
// rtl/adventure_pkg.sv - shared move encoding and replay state types for the adventure game
package adventure_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } play_state_t;

    // Bit order matches the {N, S, E, W} output bundle.
    function automatic logic [3:0] dir_to_onehot(input dir_t dir);
        logic [3:0] oh;
        case (dir)
            DIR_N:   oh = 4'b1000;
            DIR_S:   oh = 4'b0100;
            DIR_E:   oh = 4'b0010;
            default: oh = 4'b0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/adventure_autoplayer_route_mem.sv
// rtl/adventure_autoplayer_route_mem.sv - route storage array with saturating length counter
module route_mem #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [1:0]                 wr_dir,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [1:0]                 rd_dir,
    output logic [$clog2(DEPTH+1)-1:0] len,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [1:0] mem [DEPTH];
    logic       wr_accept;

    assign full      = (len == LW'(DEPTH));
    assign wr_accept = wr_en && !clear && !full;
    assign rd_dir    = mem[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len <= '0;
        end else if (clear) begin
            len <= '0;
        end else if (wr_accept) begin
            len <= len + LW'(1);
        end
    end

    // Contents need no reset; len alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[len[AW-1:0]] <= wr_dir;
        end
    end

endmodule

// File: rtl/adventure_autoplayer.sv
// rtl/adventure_autoplayer.sv - replays a stored N/S/E/W route into the game and reports the outcome
module adventure_autoplayer
    import adventure_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [1:0]                 wr_dir,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       WIN,
    input  logic                       DIE,
    output logic                       N,
    output logic                       S,
    output logic                       E,
    output logic                       W,
    output logic                       busy,
    output logic                       done,
    output logic                       won,
    output logic                       died,
    output logic [$clog2(DEPTH+1)-1:0] moves_issued,
    output logic [$clog2(DEPTH+1)-1:0] route_len,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    play_state_t   state, state_n;
    logic [LW-1:0] rd_ptr, rd_ptr_n;
    logic [LW-1:0] moves_n;
    logic [LW-1:0] start_len;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          won_n, died_n;
    logic [3:0]    pulse, pulse_n;
    logic          idle_like, mem_clear, mem_wr, wr_accept;
    logic [AW-1:0] rd_idx;
    logic [1:0]    rd_dir;
    dir_t          issue_dir;

    route_mem #(.DEPTH(DEPTH)) u_route_mem (
        .clk    (clk),
        .reset  (reset),
        .clear  (mem_clear),
        .wr_en  (mem_wr),
        .wr_dir (wr_dir),
        .rd_idx (rd_idx),
        .rd_dir (rd_dir),
        .len    (route_len),
        .full   (full)
    );

    // A start in the same cycle as a write sees the post-write length, and the
    // first move may be the one being written, so it bypasses the array read.
    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        mem_clear = clear && idle_like;
        mem_wr    = wr_en && idle_like;
        wr_accept = mem_wr && !mem_clear && !full;
        start_len = mem_clear ? '0 : route_len + LW'(wr_accept);
        rd_idx    = idle_like ? '0 : rd_ptr[AW-1:0];
        issue_dir = dir_t'((idle_like && (route_len == '0)) ? wr_dir : rd_dir);
    end

    always_comb begin
        state_n  = state;
        rd_ptr_n = rd_ptr;
        moves_n  = moves_issued;
        gap_n    = gap_cnt;
        won_n    = won;
        died_n   = died;
        pulse_n  = 4'b0000;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    rd_ptr_n = '0;
                    moves_n  = '0;
                    won_n    = 1'b0;
                    died_n   = 1'b0;
                    if (start_len != '0) begin
                        state_n = ISSUE;
                        pulse_n = dir_to_onehot(issue_dir);
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            ISSUE: begin
                rd_ptr_n = rd_ptr + LW'(1);
                moves_n  = moves_issued + LW'(1);
                gap_n    = GW'(GAP_CYCLES - 1);
                state_n  = GAP;
            end
            GAP: begin
                if (DIE) begin
                    died_n  = 1'b1;
                    state_n = DONE;
                end else if (WIN) begin
                    won_n   = 1'b1;
                    state_n = DONE;
                end else if (gap_cnt == '0) begin
                    if (rd_ptr < route_len) begin
                        state_n = ISSUE;
                        pulse_n = dir_to_onehot(issue_dir);
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            moves_issued <= '0;
            gap_cnt      <= '0;
            won          <= 1'b0;
            died         <= 1'b0;
            pulse        <= 4'b0000;
        end else begin
            state        <= state_n;
            rd_ptr       <= rd_ptr_n;
            moves_issued <= moves_n;
            gap_cnt      <= gap_n;
            won          <= won_n;
            died         <= died_n;
            pulse        <= pulse_n;
        end
    end

    assign {N, S, E, W} = pulse;
    assign busy = (state == ISSUE) || (state == GAP);
    assign done = (state == DONE);

endmodule

// File: tb/tb_adventure_autoplayer.sv
// tb/tb_adventure_autoplayer.sv - randomized self-checking bench for adventure_autoplayer
module tb_adventure_autoplayer;
    localparam int DEPTH = 16;
    localparam int G     = 2;
    localparam int LW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, clear, start, WIN, DIE;
    logic [1:0]    wr_dir;
    logic          N, S, E, W, busy, done, won, died, full;
    logic [LW-1:0] moves_issued, route_len;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  route_q[$];

    adventure_autoplayer #(.DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_dir       (wr_dir),
        .clear        (clear),
        .start        (start),
        .WIN          (WIN),
        .DIE          (DIE),
        .N            (N),
        .S            (S),
        .E            (E),
        .W            (W),
        .busy         (busy),
        .done         (done),
        .won          (won),
        .died         (died),
        .moves_issued (moves_issued),
        .route_len    (route_len),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_move(input logic [1:0] d);
        wr_en  = 1'b1;
        wr_dir = d;
        if (route_q.size() < DEPTH) route_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_route();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        route_q.delete();
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) write_move(2'($urandom_range(0, 3)));
        check("route_len", 32'(route_len), 32'(route_q.size()));
        check("full", 32'(full), 32'(route_q.size() == DEPTH));
    endtask

    // kind: 0 none, 1 WIN, 2 DIE, 3 both; flags pulse for one cycle, stop_off
    // cycles after pulse number stop_k (offset 0 lands on the pulse itself).
    task automatic run_scenario(input int stop_k, input int stop_off, input int kind);
        int len, n_iss, done_cycle, flag_cycle, j;
        logic exp_won, exp_died;
        logic [3:0] exp_pulse;
        len        = route_q.size();
        exp_won    = 1'b0;
        exp_died   = 1'b0;
        flag_cycle = -1;
        if (kind != 0 && stop_k >= 1 && stop_k <= len)
            flag_cycle = 1 + (stop_k - 1) * (G + 1) + stop_off;
        if (len == 0) begin
            n_iss      = 0;
            done_cycle = 1;
        end else if (flag_cycle > 0 && stop_off >= 1) begin
            n_iss      = stop_k;
            done_cycle = flag_cycle + 1;
            exp_died   = (kind >= 2);
            exp_won    = (kind == 1);
        end else begin
            n_iss      = len;
            done_cycle = len * (G + 1) + 1;
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= done_cycle + 1; c++) begin
            j = (c - 1) / (G + 1);
            exp_pulse = 4'b0000;
            if ((c - 1) % (G + 1) == 0 && j < n_iss) exp_pulse = 4'b1000 >> route_q[j];
            check("pulse", 32'({N, S, E, W}), 32'(exp_pulse));
            check("busy", 32'(busy), 32'(c < done_cycle));
            check("done", 32'(done), 32'(c >= done_cycle));
            WIN    = (c == flag_cycle) && (kind == 1 || kind == 3);
            DIE    = (c == flag_cycle) && (kind >= 2);
            wr_en  = (c < done_cycle) && ($urandom_range(0, 2) == 0);
            clear  = (c < done_cycle) && ($urandom_range(0, 5) == 0);
            wr_dir = 2'($urandom_range(0, 3));
            tick();
        end
        {WIN, DIE, wr_en, clear} = 4'b0000;
        check("done_hold", 32'(done), 32'(1));
        check("won", 32'(won), 32'(exp_won));
        check("died", 32'(died), 32'(exp_died));
        check("moves_issued", 32'(moves_issued), 32'(n_iss));
        check("route_len_kept", 32'(route_len), 32'(len));
    endtask

    initial begin
        int n, k, kind;
        reset = 1'b0;
        {wr_en, clear, start, WIN, DIE} = 5'b00000;
        wr_dir = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'({N, S, E, W, busy, done, won, died, full}), 32'(0));
        check("rst_moves", 32'(moves_issued), 32'(0));
        check("rst_len", 32'(route_len), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();

        write_move(2'd2);
        write_move(2'd0);
        write_move(2'd3);
        check("len3", 32'(route_len), 32'(3));
        run_scenario(0, 0, 0);

        clear_route();
        load_random(5);
        run_scenario(2, 1, 2);
        run_scenario(1, 1, 3);

        clear_route();
        check("clear_done", 32'(done), 32'(1));
        check("clear_died", 32'(died), 32'(1));
        check("clear_won", 32'(won), 32'(0));
        load_random(17);

        clear_route();
        run_scenario(0, 0, 0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) clear_route();
            n = $urandom_range(0, 6);
            load_random(n);
            kind = $urandom_range(0, 3);
            k    = $urandom_range(1, route_q.size() + 1);
            run_scenario(k, $urandom_range(0, G), kind);
        end

        clear_route();
        load_random(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        route_q.delete();
        check("arst_outs", 32'({N, S, E, W, busy, done, won, died, full}), 32'(0));
        check("arst_moves", 32'(moves_issued), 32'(0));
        check("arst_len", 32'(route_len), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_scenario(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
